// File: rtl/ctrl_pkg.sv
// Shared constants and types for the multicycle RV32I controller.
// Covers opcodes, ALU operation encoding, FSM state encoding and datapath mux selects.
package ctrl_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5,
    ST_TRAP   = 3'd6
  } ctrl_state_e;

  localparam logic [1:0] PC_PLUS4     = 2'b00;
  localparam logic [1:0] PC_ALU       = 2'b01;
  localparam logic [1:0] PC_ALU_ALIGN = 2'b10;

  localparam logic [1:0] SRC_A_RS1  = 2'b00;
  localparam logic [1:0] SRC_A_PC   = 2'b01;
  localparam logic [1:0] SRC_A_ZERO = 2'b10;
  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  function automatic logic opc_legal(input logic [6:0] opc);
    return (opc == OPC_R)      || (opc == OPC_IMM)  || (opc == OPC_LOAD) ||
           (opc == OPC_STORE)  || (opc == OPC_BRANCH) || (opc == OPC_JAL) ||
           (opc == OPC_JALR)   || (opc == OPC_LUI)  || (opc == OPC_AUIPC);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Shared instruction/data memory handshake between the controller and the memory port.
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic mem_addr_sel;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output mem_addr_sel, input mem_ready);
  modport slave  (input mem_req, input mem_we, input mem_addr_sel, output mem_ready);
endinterface

// File: rtl/alu_op_decode.sv
// Combinational opcode/funct3/funct7 -> ALU operation; the result is held across EXEC, MEM and WB.
module alu_op_decode
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output alu_op_e    alu_op
);

  logic alt;
  logic is_r;

  always_comb begin
    alt    = (funct7 == 7'b0100000);
    is_r   = (opcode == OPC_R);
    alu_op = ALU_ADD;
    if (opcode == OPC_BRANCH) begin
      alu_op = ALU_SUB;
    end else if (is_r || (opcode == OPC_IMM)) begin
      case (funct3)
        3'b000:  alu_op = (is_r && alt) ? ALU_SUB : ALU_ADD;  // addi has no sub form
        3'b001:  alu_op = ALU_SLL;
        3'b010:  alu_op = ALU_SLT;
        3'b011:  alu_op = ALU_SLTU;
        3'b100:  alu_op = ALU_XOR;
        3'b101:  alu_op = alt ? ALU_SRA : ALU_SRL;
        3'b110:  alu_op = ALU_OR;
        default: alu_op = ALU_AND;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// FSM controller sequencing a multicycle RV32I datapath over a shared memory port.
// Define MULTICYCLE_CTRL_PERF_EN to add cycle_cnt / instret_cnt performance counters.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt_req,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  multicycle_ctrl_if.master bus,
  input  logic              alu_zero,
  input  logic              alu_lt,
  input  logic              alu_ltu,
  output logic              ir_we,
  output logic              pc_we,
  output logic [1:0]        pc_src,
  output logic [1:0]        alu_src_a,
  output logic [1:0]        alu_src_b,
  output logic [3:0]        alu_op,
  output logic              reg_we,
  output logic [1:0]        wb_sel,
  output logic              halted,
  output logic              illegal,
  output logic              bus_err,
  output logic [2:0]        state_dbg
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [31:0]       cycle_cnt,
  output logic [31:0]       instret_cnt
`endif
);

  localparam int WAIT_W = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;

  ctrl_state_e state_reg, state_next;
  logic        illegal_reg, bus_err_reg;
  logic        set_illegal, set_bus_err;
  logic        timeout;
  logic        req_state;
  logic        mem_req_c, mem_we_c, mem_addr_sel_c;
  alu_op_e     dec_op;

  logic is_r, is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc;
  logic br_taken, br_bad;
  logic [1:0] src_a, src_b;

  assign is_r      = (opcode == OPC_R);
  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign is_branch = (opcode == OPC_BRANCH);
  assign is_jal    = (opcode == OPC_JAL);
  assign is_jalr   = (opcode == OPC_JALR);
  assign is_lui    = (opcode == OPC_LUI);
  assign is_auipc  = (opcode == OPC_AUIPC);

  assign src_a = is_lui ? SRC_A_ZERO : ((is_jal || is_auipc) ? SRC_A_PC : SRC_A_RS1);
  assign src_b = (is_r || is_branch) ? SRC_B_RS2 : SRC_B_IMM;

  alu_op_decode u_alu_op_decode (
    .opcode (opcode),
    .funct3 (funct3),
    .funct7 (funct7),
    .alu_op (dec_op)
  );

  always_comb begin
    br_taken = 1'b0;
    br_bad   = 1'b0;
    case (funct3)
      3'b000:  br_taken = alu_zero;
      3'b001:  br_taken = !alu_zero;
      3'b100:  br_taken = alu_lt;
      3'b101:  br_taken = !alu_lt;
      3'b110:  br_taken = alu_ltu;
      3'b111:  br_taken = !alu_ltu;
      default: br_bad   = 1'b1;
    endcase
  end

  assign req_state = (state_reg == ST_FETCH) || (state_reg == ST_MEM);

  // Trap on the edge where the wait count would reach WAIT_LIMIT, so a request
  // is held for at most WAIT_LIMIT cycles; a same-cycle mem_ready always wins.
  generate
    if (WAIT_LIMIT > 0) begin : g_timeout
      logic [WAIT_W-1:0] wait_reg, wait_next;

      assign timeout = req_state && !bus.mem_ready &&
                       (wait_reg == WAIT_W'(WAIT_LIMIT - 1));

      always_comb begin
        wait_next = '0;
        if (req_state && !bus.mem_ready && !timeout) begin
          wait_next = wait_reg + WAIT_W'(1);
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          wait_reg <= '0;
        end else begin
          wait_reg <= wait_next;
        end
      end
    end else begin : g_no_timeout
      assign timeout = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_FETCH;
      illegal_reg <= 1'b0;
      bus_err_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (set_illegal) illegal_reg <= 1'b1;
      if (set_bus_err) bus_err_reg <= 1'b1;
    end
  end

  always_comb begin
    state_next  = state_reg;
    set_illegal = 1'b0;
    set_bus_err = 1'b0;
    case (state_reg)
      ST_FETCH: begin
        if (bus.mem_ready) begin
          state_next = ST_DECODE;
        end else if (timeout) begin
          state_next  = ST_TRAP;
          set_bus_err = 1'b1;
        end
      end
      ST_DECODE: begin
        if (!opc_legal(opcode)) begin
          state_next  = ST_TRAP;
          set_illegal = 1'b1;
        end else begin
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (is_load || is_store) begin
          state_next = ST_MEM;
        end else if (is_branch && br_bad) begin
          state_next  = ST_TRAP;
          set_illegal = 1'b1;
        end else if (is_branch || is_jal || is_jalr) begin
          state_next = ST_FETCH;
        end else begin
          state_next = ST_WB;
        end
      end
      ST_MEM: begin
        if (bus.mem_ready) begin
          state_next = is_store ? ST_FETCH : ST_WB;
        end else if (timeout) begin
          state_next  = ST_TRAP;
          set_bus_err = 1'b1;
        end
      end
      ST_WB:   state_next = ST_FETCH;
      ST_HALT: if (!halt_req) state_next = ST_FETCH;
      ST_TRAP: state_next = ST_TRAP;
      default: state_next = ST_FETCH;
    endcase
    // Instruction boundary: a halt request diverts the FETCH entry into HALT.
    if ((state_next == ST_FETCH) && (state_reg != ST_FETCH) && halt_req) begin
      state_next = ST_HALT;
    end
  end

  always_comb begin
    mem_req_c      = 1'b0;
    mem_we_c       = 1'b0;
    mem_addr_sel_c = 1'b0;
    ir_we          = 1'b0;
    pc_we          = 1'b0;
    pc_src         = PC_PLUS4;
    alu_src_a      = SRC_A_RS1;
    alu_src_b      = SRC_B_RS2;
    alu_op         = ALU_ADD;
    reg_we         = 1'b0;
    wb_sel         = WB_ALU;
    halted         = 1'b0;
    if (!rst) begin
      case (state_reg)
        ST_FETCH: begin
          mem_req_c = 1'b1;
          ir_we     = bus.mem_ready;
        end
        ST_EXEC: begin
          alu_src_a = src_a;
          alu_src_b = src_b;
          alu_op    = dec_op;
          if (is_branch && !br_bad) begin
            pc_we  = 1'b1;
            pc_src = br_taken ? PC_ALU : PC_PLUS4;
          end
          // Link write and jump share one edge; the ALU already holds the old rs1.
          if (is_jal || is_jalr) begin
            reg_we = 1'b1;
            wb_sel = WB_PC4;
            pc_we  = 1'b1;
            pc_src = is_jalr ? PC_ALU_ALIGN : PC_ALU;
          end
        end
        ST_MEM: begin
          alu_src_a      = src_a;
          alu_src_b      = src_b;
          alu_op         = dec_op;
          mem_req_c      = 1'b1;
          mem_addr_sel_c = 1'b1;
          mem_we_c       = is_store;
          if (bus.mem_ready && is_store) pc_we = 1'b1;
        end
        ST_WB: begin
          alu_src_a = src_a;
          alu_src_b = src_b;
          alu_op    = dec_op;
          reg_we    = 1'b1;
          wb_sel    = is_load ? WB_MEM : WB_ALU;
          pc_we     = 1'b1;
        end
        ST_HALT: halted = 1'b1;
        ST_TRAP: halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.mem_req      = mem_req_c;
  assign bus.mem_we       = mem_we_c;
  assign bus.mem_addr_sel = mem_addr_sel_c;
  assign illegal          = illegal_reg;
  assign bus_err          = bus_err_reg;
  assign state_dbg        = state_reg;

`ifdef MULTICYCLE_CTRL_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt   <= 32'd0;
      instret_cnt <= 32'd0;
    end else begin
      if ((state_reg != ST_HALT) && (state_reg != ST_TRAP)) cycle_cnt <= cycle_cnt + 32'd1;
      if (pc_we) instret_cnt <= instret_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed scoreboard bench for multicycle_ctrl: each step queues the expected output
// vector for that cycle; a negedge monitor pops and compares against the DUT.
module tb_multicycle_ctrl;

  logic       clk;
  logic       rst;
  logic       halt_req;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       mem_ready;
  logic       alu_zero, alu_lt, alu_ltu;
  logic       ir_we, pc_we, reg_we, halted, illegal, bus_err;
  logic [1:0] pc_src, alu_src_a, alu_src_b, wb_sel;
  logic [3:0] alu_op;
  logic [2:0] state_dbg;

  multicycle_ctrl_if bus_if ();
  assign bus_if.mem_ready = mem_ready;

  multicycle_ctrl #(.WAIT_LIMIT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .halt_req  (halt_req),
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7    (funct7),
    .bus       (bus_if),
    .alu_zero  (alu_zero),
    .alu_lt    (alu_lt),
    .alu_ltu   (alu_ltu),
    .ir_we     (ir_we),
    .pc_we     (pc_we),
    .pc_src    (pc_src),
    .alu_src_a (alu_src_a),
    .alu_src_b (alu_src_b),
    .alu_op    (alu_op),
    .reg_we    (reg_we),
    .wb_sel    (wb_sel),
    .halted    (halted),
    .illegal   (illegal),
    .bus_err   (bus_err),
    .state_dbg (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, a, b, alu_op, reg_we, wb_sel, halted, illegal, bus_err, state}
  logic [23:0] act;
  assign act = {bus_if.mem_req, bus_if.mem_we, bus_if.mem_addr_sel, ir_we, pc_we, pc_src,
                alu_src_a, alu_src_b, alu_op, reg_we, wb_sel, halted, illegal, bus_err, state_dbg};

  string       name_q[$];
  logic [23:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  function automatic logic [23:0] ev(input logic mreq, mwe, mas, irwe, pcwe,
                                     input logic [1:0] pcs, sa, sb,
                                     input logic [3:0] op,
                                     input logic rwe,
                                     input logic [1:0] wbs,
                                     input logic hlt, ill, berr,
                                     input logic [2:0] st);
    return {mreq, mwe, mas, irwe, pcwe, pcs, sa, sb, op, rwe, wbs, hlt, ill, berr, st};
  endfunction

  function automatic logic [23:0] fe(input logic rdy);
    return ev(1, 0, 0, rdy, 0, 2'b00, 2'b00, 2'b00, 4'h0, 0, 2'b00, 0, 0, 0, 3'd0);
  endfunction

  function automatic logic [23:0] dec();
    return ev(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'h0, 0, 2'b00, 0, 0, 0, 3'd1);
  endfunction

  task automatic set_ir(input logic [31:0] ir);
    opcode = ir[6:0];
    funct3 = ir[14:12];
    funct7 = ir[31:25];
  endtask

  task automatic step(input string nm, input logic [23:0] e);
    name_q.push_back(nm);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    string       nm;
    logic [23:0] e;
    if (exp_q.size() != 0) begin
      nm = name_q.pop_front();
      e  = exp_q.pop_front();
      n_vec++;
      if (act !== e) begin
        n_err++;
        $display("FAIL %s: got %h required %h", nm, act, e);
      end else begin
        $display("ok   %s: %h", nm, act);
      end
    end
  end

  initial begin
    rst = 1'b1; halt_req = 1'b0; mem_ready = 1'b0;
    alu_zero = 1'b0; alu_lt = 1'b0; alu_ltu = 1'b0;
    set_ir(32'h0);
    @(posedge clk);
    #1;

    // Reset, including an async reset in the middle of a FETCH request
    step("reset0", 24'h0);
    step("reset1", 24'h0);
    rst = 1'b0; step("fetch_wait", fe(0));
    rst = 1'b1; step("rst_mid_fetch", 24'h0);
    rst = 1'b0; step("post_rst", fe(0));

    // add x3,x1,x2
    set_ir(32'h002081B3); mem_ready = 1'b1; step("add_fetch", fe(1));
    mem_ready = 1'b0; step("add_decode", dec());
    step("add_exec", ev(0,0,0,0,0, 2'b00, 2'b00, 2'b00, 4'h0, 0, 2'b00, 0,0,0, 3'd2));
    step("add_wb",   ev(0,0,0,0,1, 2'b00, 2'b00, 2'b00, 4'h0, 1, 2'b00, 0,0,0, 3'd4));

    // lw with three wait cycles in MEM
    set_ir(32'h00002003); mem_ready = 1'b1; step("lw_fetch", fe(1));
    mem_ready = 1'b0; step("lw_decode", dec());
    step("lw_exec", ev(0,0,0,0,0, 2'b00, 2'b00, 2'b01, 4'h0, 0, 2'b00, 0,0,0, 3'd2));
    for (int i = 0; i < 3; i++)
      step("lw_mem_wait", ev(1,0,1,0,0, 2'b00, 2'b00, 2'b01, 4'h0, 0, 2'b00, 0,0,0, 3'd3));
    mem_ready = 1'b1; step("lw_mem_done", ev(1,0,1,0,0, 2'b00, 2'b00, 2'b01, 4'h0, 0, 2'b00, 0,0,0, 3'd3));
    mem_ready = 1'b0; step("lw_wb", ev(0,0,0,0,1, 2'b00, 2'b00, 2'b01, 4'h0, 1, 2'b01, 0,0,0, 3'd4));

    // sw, zero-wait
    set_ir(32'h00002023); mem_ready = 1'b1; step("sw_fetch", fe(1));
    mem_ready = 1'b0; step("sw_decode", dec());
    step("sw_exec", ev(0,0,0,0,0, 2'b00, 2'b00, 2'b01, 4'h0, 0, 2'b00, 0,0,0, 3'd2));
    mem_ready = 1'b1; step("sw_mem", ev(1,1,1,0,1, 2'b00, 2'b00, 2'b01, 4'h0, 0, 2'b00, 0,0,0, 3'd3));

    // bne taken then not taken
    set_ir(32'h00001063); step("bne_fetch", fe(1));
    mem_ready = 1'b0; step("bne_decode", dec());
    alu_zero = 1'b0; step("bne_taken", ev(0,0,0,0,1, 2'b01, 2'b00, 2'b00, 4'h1, 0, 2'b00, 0,0,0, 3'd2));
    mem_ready = 1'b1; step("bne2_fetch", fe(1));
    mem_ready = 1'b0; step("bne2_decode", dec());
    alu_zero = 1'b1; step("bne_not_taken", ev(0,0,0,0,1, 2'b00, 2'b00, 2'b00, 4'h1, 0, 2'b00, 0,0,0, 3'd2));
    alu_zero = 1'b0;

    // srai, with a halt request raised during WB
    set_ir(32'h40005013); mem_ready = 1'b1; step("srai_fetch", fe(1));
    mem_ready = 1'b0; step("srai_decode", dec());
    step("srai_exec", ev(0,0,0,0,0, 2'b00, 2'b00, 2'b01, 4'h7, 0, 2'b00, 0,0,0, 3'd2));
    halt_req = 1'b1; step("srai_wb_halt", ev(0,0,0,0,1, 2'b00, 2'b00, 2'b01, 4'h7, 1, 2'b00, 0,0,0, 3'd4));
    step("halt_hold", ev(0,0,0,0,0, 2'b00, 2'b00, 2'b00, 4'h0, 0, 2'b00, 1,0,0, 3'd5));
    halt_req = 1'b0; step("halt_release", ev(0,0,0,0,0, 2'b00, 2'b00, 2'b00, 4'h0, 0, 2'b00, 1,0,0, 3'd5));

    // jal, mem_ready arriving exactly at the wait limit
    set_ir(32'h0000006F);
    for (int i = 0; i < 3; i++) step("jal_fetch_wait", fe(0));
    mem_ready = 1'b1; step("jal_fetch_at_limit", fe(1));
    mem_ready = 1'b0; step("jal_decode", dec());
    step("jal_exec", ev(0,0,0,0,1, 2'b01, 2'b01, 2'b01, 4'h0, 1, 2'b10, 0,0,0, 3'd2));

    // jalr
    set_ir(32'h00000067); mem_ready = 1'b1; step("jalr_fetch", fe(1));
    mem_ready = 1'b0; step("jalr_decode", dec());
    step("jalr_exec", ev(0,0,0,0,1, 2'b10, 2'b00, 2'b01, 4'h0, 1, 2'b10, 0,0,0, 3'd2));

    // lui
    set_ir(32'h00000037); mem_ready = 1'b1; step("lui_fetch", fe(1));
    mem_ready = 1'b0; step("lui_decode", dec());
    step("lui_exec", ev(0,0,0,0,0, 2'b00, 2'b10, 2'b01, 4'h0, 0, 2'b00, 0,0,0, 3'd2));
    step("lui_wb",   ev(0,0,0,0,1, 2'b00, 2'b10, 2'b01, 4'h0, 1, 2'b00, 0,0,0, 3'd4));

    // Illegal opcode: trap persists with no memory requests
    set_ir(32'h0000007F); mem_ready = 1'b1; step("ill_fetch", fe(1));
    step("ill_decode", dec());
    step("ill_trap0", ev(0,0,0,0,0, 2'b00, 2'b00, 2'b00, 4'h0, 0, 2'b00, 1,1,0, 3'd6));
    step("ill_trap1", ev(0,0,0,0,0, 2'b00, 2'b00, 2'b00, 4'h0, 0, 2'b00, 1,1,0, 3'd6));
    rst = 1'b1; step("ill_reset", 24'h0);

    // Memory timeout in FETCH with WAIT_LIMIT = 4
    rst = 1'b0; mem_ready = 1'b0; set_ir(32'h002081B3);
    for (int i = 0; i < 4; i++) step("to_fetch_wait", fe(0));
    step("to_trap0", ev(0,0,0,0,0, 2'b00, 2'b00, 2'b00, 4'h0, 0, 2'b00, 1,0,1, 3'd6));
    step("to_trap1", ev(0,0,0,0,0, 2'b00, 2'b00, 2'b00, 4'h0, 0, 2'b00, 1,0,1, 3'd6));
    rst = 1'b1; step("to_reset", 24'h0);
    rst = 1'b0; step("final_fetch", fe(0));

    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending vectors required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- FSM controller that sequences a multi-cycle RV32I datapath: shared instruction/data memory port, IR, PC, register file, and the existing 4-bit ALU operation encoding.
- Decodes opcode/funct3/funct7 from the datapath IR each instruction.
- Drives per-state mux selects, write enables and memory handshake.
- Handles halt requests at instruction boundaries, illegal-opcode traps and memory-wait timeouts.

Parameters:
WAIT_LIMIT, 255, max cycles a memory request may wait for mem_ready before bus-error trap; 0 disables timeout
WAIT_W, $clog2(WAIT_LIMIT+1), wait counter width (derived, not overridden)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
halt_req  in  1  request stop at next instruction boundary
opcode  in  7  IR[6:0]
funct3  in  3  IR[14:12]
funct7  in  7  IR[31:25]
mem_ready  in  1  memory completes current request this cycle
alu_zero  in  1  ALU result == 0
alu_lt  in  1  signed rs1 < rs2
alu_ltu  in  1  unsigned rs1 < rs2
mem_req  out  1  memory request valid
mem_we  out  1  store when mem_req
mem_addr_sel  out  1  0 = PC, 1 = ALU result
ir_we  out  1  load IR from memory read data
pc_we  out  1  update PC
pc_src  out  2  00 = PC+4, 01 = ALU result, 10 = ALU result & ~1
alu_src_a  out  2  00 = rs1, 01 = PC, 10 = zero
alu_src_b  out  2  00 = rs2, 01 = imm
alu_op  out  4  0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 sll, 0110 srl, 0111 sra, 1000 slt, 1001 sltu
reg_we  out  1  register file write
wb_sel  out  2  00 = ALU, 01 = memory data, 10 = PC+4
halted  out  1  in HALT or TRAP
illegal  out  1  sticky: illegal opcode trap
bus_err  out  1  sticky: memory timeout trap
state_dbg  out  3  current state encoding

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, HALT, TRAP.
- Outputs are combinational from state and IR fields, except sticky flags and counters.
- Every output defaults to 0 in every state.
- Reset (async, any time, including mid-handshake):
  - state = FETCH; illegal = bus_err = 0; wait counter = 0.
  - All outputs 0 while rst is high; mem_req drops immediately.
- FETCH:
  - mem_req = 1, mem_addr_sel = 0.
  - On mem_ready: ir_we = 1 that cycle, go to DECODE.
- DECODE: one cycle.
  - Opcode not in {R, I-ALU, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC}: go to TRAP, set illegal.
  - Otherwise go to EXEC.
- EXEC:
  - R: a = 00, b = 00, alu_op from {funct7, funct3}. Go to WB.
  - I-ALU: a = 00, b = 01, alu_op from funct3. funct3 = 101 with funct7 = 0100000 gives sra. Go to WB.
  - LOAD/STORE: a = 00, b = 01, add. Go to MEM.
  - BRANCH: a = 00, b = 00, sub.
    - Taken per funct3: beq zero, bne !zero, blt lt, bge !lt, bltu ltu, bgeu !ltu; funct3 010/011 traps as illegal.
    - pc_we = 1, pc_src = taken ? 01 : 00. Go to FETCH.
  - JAL: a = 01, b = 01, add. reg_we = 1, wb_sel = 10, pc_we = 1, pc_src = 01, same edge. Go to FETCH.
  - JALR: same as JAL but a = 00, pc_src = 10. rd == rs1 is safe because the ALU uses the old rs1.
  - LUI: a = 10, b = 01, add. Go to WB.
  - AUIPC: a = 01, b = 01, add. Go to WB.
- MEM:
  - mem_req = 1, mem_addr_sel = 1, mem_we = STORE. ALU select/op signals are held from EXEC.
  - On mem_ready: STORE sets pc_we = 1, pc_src = 00, goes to FETCH; LOAD goes to WB.
- WB:
  - reg_we = 1, wb_sel = LOAD ? 01 : 00. ALU controls are held from EXEC.
  - pc_we = 1, pc_src = 00. Go to FETCH.
- Instruction boundary = any transition into FETCH.
  - If halt_req = 1 on that cycle, go to HALT instead; the PC update still occurs.
  - HALT: halted = 1; leave to FETCH when halt_req = 0.
- TRAP: halted = 1, all enables 0. Exit only by reset.
- Timeout (WAIT_LIMIT > 0):
  - Counter clears on entry to FETCH/MEM and on mem_ready; increments each cycle mem_req = 1 and mem_ready = 0.
  - When the count reaches WAIT_LIMIT with no mem_ready: go to TRAP, set bus_err, drop mem_req.
  - mem_ready in the same cycle as the limit wins (no trap).
- Latency with zero-wait memory: R/I/LUI/AUIPC/STORE 4 cycles; LOAD 5; BRANCH/JAL/JALR 3.

Optional Feature:
- Macro: MULTICYCLE_CTRL_PERF_EN.
- Defined: adds outputs cycle_cnt (32) and instret_cnt (32), both reset to 0 and wrapping modulo 2^32.
  - cycle_cnt increments every cycle not in HALT/TRAP.
  - instret_cnt increments on every pc_we.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Package ctrl_pkg:
  - opcode constants (OPC_R, OPC_IMM, OPC_LOAD, ...).
  - alu_op_e enum (4-bit, encodings above).
  - ctrl_state_e (3-bit).
  - pc_src/alu_src/wb_sel constants.
- Sub-module alu_op_decode: combinational opcode/funct3/funct7 -> alu_op, reused from EXEC, MEM and WB.

Test Plan:
- Reset mid-FETCH with mem_req = 1 -> mem_req = 0 same cycle; after release state_dbg = FETCH, illegal = bus_err = 0.
- add (0x002081B3), zero-wait memory -> FETCH/DECODE/EXEC/WB in 4 cycles; alu_op = 0000, reg_we = 1 only in WB, pc_we = 1 only in WB with pc_src = 00.
- lw with mem_ready delayed 3 cycles in MEM -> mem_req = 1, mem_addr_sel = 1 held 4 cycles; WB wb_sel = 01; 8 cycles total.
- bne with alu_zero = 0 -> EXEC pc_we = 1, pc_src = 01; with alu_zero = 1 -> pc_src = 00; next state FETCH.
- opcode 0x7F -> TRAP after DECODE, illegal = 1, halted = 1, no further mem_req until reset.
- WAIT_LIMIT = 4, mem_ready held low in FETCH -> bus_err = 1 after 4 cycles. Separately, halt_req = 1 during WB -> HALT, then release halt_req -> FETCH.
